// File: rtl/seg7_pkg.sv
// Shared glyph constants and state types for the seven-segment scan monitor.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Alternate renderings some display controllers use for 7 and 9
  localparam logic [6:0] ALT_SEVEN = 7'h58;
  localparam logic [6:0] ALT_NINE  = 7'h18;

  typedef enum logic [1:0] {GLYPH_HEX, GLYPH_BLANK, GLYPH_BAD} glyph_class_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, PUBLISH} frame_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex-to-7-segment encoder: segment pattern to {class, nibble}.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 7 and 9 glyphs.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segment,
  output logic [1:0] glyph_class,
  output logic [3:0] nibble
);

  glyph_class_t cls;

  always_comb begin
    cls    = GLYPH_HEX;
    nibble = 4'h0;
    case (segment)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: cls = GLYPH_BLANK;
`ifdef SEG7_ALT_GLYPH_EN
      ALT_SEVEN: nibble = 4'h7;
      ALT_NINE:  nibble = 4'h9;
`endif
      default:   cls = GLYPH_BAD;
    endcase
  end

  assign glyph_class = cls;

endmodule

// File: rtl/seg7_scan_capture.sv
// Passive monitor of a multiplexed active-low 7-segment display; rebuilds the shown hex frame.
// Optional alternate glyph support is selected with SEG7_ALT_GLYPH_EN (see seg7_glyph_decode).
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DIGITS-1:0]     anode,
  input  logic [6:0]                segment,
  input  logic                      err_clr,
  output logic [4*NUM_DIGITS-1:0]   hex_out,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     digit_blank,
  output logic                      frame_done,
  output logic                      glyph_err,
  output logic                      anode_err
);

  localparam int         SW         = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_SAT    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]           sample_q;
  logic [7:0]              cnt_q;
  logic [NUM_DIGITS-1:0]   low_mask;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic [NUM_DIGITS-1:0]   shadow_valid;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [4*NUM_DIGITS-1:0] shadow_hex;
  logic [1:0]              glyph_class;
  logic [3:0]              nibble;
  logic                    commit;
  logic                    one_low;
  logic                    single_commit;
  logic                    multi_commit;
  logic                    bad_glyph;
  frame_state_t            state_q;
  frame_state_t            state_next;

  seg7_glyph_decode u_decode (
    .segment     (sample_q[6:0]),
    .glyph_class (glyph_class),
    .nibble      (nibble)
  );

  assign low_mask      = ~sample_q[SW-1:7];
  assign commit        = (cnt_q == CNT_COMMIT);
  assign one_low       = (low_mask != '0) && ((low_mask & (low_mask - NUM_DIGITS'(1))) == '0);
  assign single_commit = commit && one_low;
  assign multi_commit  = commit && (low_mask != '0) && !one_low;
  assign bad_glyph     = single_commit && (glyph_class == GLYPH_BAD);

  // The counter saturates so that a long dwell commits only once, when it first hits CNT_COMMIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      cnt_q    <= '0;
    end else begin
      sample_q <= {anode, segment};
      if ({anode, segment} == sample_q) begin
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Seen restarts from empty while publishing, so a commit landing on that cycle opens the next frame
  always_comb begin
    seen_next  = (state_q == PUBLISH) ? '0 : seen_q;
    state_next = IDLE;
    if (single_commit) seen_next = seen_next | low_mask;
    if (&seen_next)              state_next = PUBLISH;
    else if (seen_next != '0)    state_next = CAPTURE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q       <= '0;
      shadow_hex   <= '0;
      shadow_valid <= '0;
      shadow_blank <= '0;
      hex_out      <= '0;
      digit_valid  <= '0;
      digit_blank  <= '0;
      frame_done   <= 1'b0;
      glyph_err    <= 1'b0;
      anode_err    <= 1'b0;
    end else begin
      seen_q     <= seen_next;
      frame_done <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        hex_out     <= shadow_hex;
        digit_valid <= shadow_valid;
        digit_blank <= shadow_blank;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (single_commit && low_mask[i]) begin
          shadow_hex[4*i +: 4] <= (glyph_class == GLYPH_HEX) ? nibble : 4'h0;
          shadow_valid[i]      <= (glyph_class == GLYPH_HEX);
          shadow_blank[i]      <= (glyph_class == GLYPH_BLANK);
        end
      end
      glyph_err <= bad_glyph    | (glyph_err & ~err_clr);
      anode_err <= multi_commit | (anode_err & ~err_clr);
    end
  end

endmodule
